// File: rtl/axirdarbiter.sv
// Round-robin arbiter sharing one AXI4 read slave port among NM read masters.
// One burst in flight at a time; the grant is held from AR acceptance until RLAST.
module axirdarbiter #(
    parameter int NM               = 2,
    parameter int C_AXI_ID_WIDTH   = 2,
    parameter int C_AXI_ADDR_WIDTH = 32,
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter bit OPT_LOWPOWER     = 1'b0
) (
    input  logic                             S_AXI_ACLK,
    input  logic                             S_AXI_ARESETN,
    input  logic [NM-1:0]                    S_AXI_ARVALID,
    output logic [NM-1:0]                    S_AXI_ARREADY,
    input  logic [NM*C_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
    input  logic [NM*C_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [NM*8-1:0]                  S_AXI_ARLEN,
    output logic [NM-1:0]                    S_AXI_RVALID,
    input  logic [NM-1:0]                    S_AXI_RREADY,
    output logic [C_AXI_ID_WIDTH-1:0]        S_AXI_RID,
    output logic [C_AXI_DATA_WIDTH-1:0]      S_AXI_RDATA,
    output logic [1:0]                       S_AXI_RRESP,
    output logic                             S_AXI_RLAST,
    output logic                             M_AXI_ARVALID,
    input  logic                             M_AXI_ARREADY,
    output logic [C_AXI_ID_WIDTH-1:0]        M_AXI_ARID,
    output logic [C_AXI_ADDR_WIDTH-1:0]      M_AXI_ARADDR,
    output logic [7:0]                       M_AXI_ARLEN,
    input  logic                             M_AXI_RVALID,
    output logic                             M_AXI_RREADY,
    input  logic [C_AXI_ID_WIDTH-1:0]        M_AXI_RID,
    input  logic [C_AXI_DATA_WIDTH-1:0]      M_AXI_RDATA,
    input  logic [1:0]                       M_AXI_RRESP,
    input  logic                             M_AXI_RLAST
);
    // state  | meaning
    // S_IDLE | no burst owned; winner's AR accepted combinationally
    // S_ADDR | latched AR presented downstream until M_AXI_ARREADY
    // S_DATA | R channel routed to grant_q until the RLAST beat is taken

    localparam int GW = (NM > 1) ? $clog2(NM) : 1;
    localparam int IW = C_AXI_ID_WIDTH;
    localparam int AW = C_AXI_ADDR_WIDTH;
    localparam int DW = C_AXI_DATA_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

    state_t        state_q;
    logic [GW-1:0] grant_q, last_q, grant_d;
    logic          grant_vld;
    logic          arvalid_q;
    logic [IW-1:0] arid_q, arid_d;
    logic [AW-1:0] araddr_q, araddr_d;
    logic [7:0]    arlen_q, arlen_d;
    logic          ar_take;
    logic          in_data;
    logic          m_rready;
    logic          r_done;
    logic          rpass;
    logic [NM-1:0] s_rvalid;

    // Search masters after last_q first, then wrap to 0..last_q.
    always_comb begin
        grant_vld = 1'b0;
        grant_d   = '0;
        arid_d    = '0;
        araddr_d  = '0;
        arlen_d   = '0;
        for (int k = 0; k < NM; k++) begin
            if (!grant_vld && (k > int'(last_q)) && S_AXI_ARVALID[k]) begin
                grant_vld = 1'b1;
                grant_d   = GW'(k);
                arid_d    = S_AXI_ARID[k*IW +: IW];
                araddr_d  = S_AXI_ARADDR[k*AW +: AW];
                arlen_d   = S_AXI_ARLEN[k*8 +: 8];
            end
        end
        for (int k = 0; k < NM; k++) begin
            if (!grant_vld && (k <= int'(last_q)) && S_AXI_ARVALID[k]) begin
                grant_vld = 1'b1;
                grant_d   = GW'(k);
                arid_d    = S_AXI_ARID[k*IW +: IW];
                araddr_d  = S_AXI_ARADDR[k*AW +: AW];
                arlen_d   = S_AXI_ARLEN[k*8 +: 8];
            end
        end
    end

    assign ar_take = S_AXI_ARESETN && (state_q == S_IDLE) && grant_vld;
    assign in_data = (state_q == S_DATA);

    always_comb begin
        S_AXI_ARREADY = '0;
        s_rvalid      = '0;
        m_rready      = 1'b0;
        for (int k = 0; k < NM; k++) begin
            S_AXI_ARREADY[k] = ar_take && (grant_d == GW'(k));
            if (in_data && (grant_q == GW'(k))) begin
                s_rvalid[k] = M_AXI_RVALID;
                m_rready    = S_AXI_RREADY[k];
            end
        end
    end

    assign r_done = in_data && M_AXI_RVALID && m_rready && M_AXI_RLAST;

    // Low-power mode keeps the shared R payload quiet when nobody is being served.
    assign rpass        = !OPT_LOWPOWER || (|s_rvalid);
    assign S_AXI_RVALID = s_rvalid;
    assign M_AXI_RREADY = m_rready;
    assign S_AXI_RID    = rpass ? M_AXI_RID   : '0;
    assign S_AXI_RDATA  = rpass ? M_AXI_RDATA : '0;
    assign S_AXI_RRESP  = rpass ? M_AXI_RRESP : '0;
    assign S_AXI_RLAST  = rpass ? M_AXI_RLAST : 1'b0;

    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_ARID    = arid_q;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARLEN   = arlen_q;

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            last_q    <= GW'(NM - 1);
            arvalid_q <= 1'b0;
            if (OPT_LOWPOWER) begin
                arid_q   <= '0;
                araddr_q <= '0;
                arlen_q  <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_vld) begin
                        grant_q   <= grant_d;
                        last_q    <= grant_d;
                        arid_q    <= arid_d;
                        araddr_q  <= araddr_d;
                        arlen_q   <= arlen_d;
                        arvalid_q <= 1'b1;
                        state_q   <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (M_AXI_ARREADY) begin
                        arvalid_q <= 1'b0;
                        state_q   <= S_DATA;
                        if (OPT_LOWPOWER) begin
                            arid_q   <= '0;
                            araddr_q <= '0;
                            arlen_q  <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (r_done) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    arvalid_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axirdarbiter.sv
// Self-checking bench for axirdarbiter: the bench plays every upstream master
// and the downstream slave, and predicts grants and routing from a transaction model.
module tb_axirdarbiter;
    localparam int NM = 2;
    localparam int IW = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rstn;
    logic [NM-1:0]       s_arvalid, s_arready, s_rvalid, s_rready;
    logic [NM*IW-1:0]    s_arid;
    logic [NM*AW-1:0]    s_araddr;
    logic [NM*8-1:0]     s_arlen;
    logic [IW-1:0]       s_rid;
    logic [DW-1:0]       s_rdata;
    logic [1:0]          s_rresp;
    logic                s_rlast;
    logic                m_arvalid, m_arready;
    logic [IW-1:0]       m_arid;
    logic [AW-1:0]       m_araddr;
    logic [7:0]          m_arlen;
    logic                m_rvalid, m_rready;
    logic [IW-1:0]       m_rid;
    logic [DW-1:0]       m_rdata;
    logic [1:0]          m_rresp;
    logic                m_rlast;

    axirdarbiter #(
        .NM(NM), .C_AXI_ID_WIDTH(IW), .C_AXI_ADDR_WIDTH(AW),
        .C_AXI_DATA_WIDTH(DW), .OPT_LOWPOWER(1'b0)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rstn),
        .S_AXI_ARVALID(s_arvalid), .S_AXI_ARREADY(s_arready),
        .S_AXI_ARID(s_arid), .S_AXI_ARADDR(s_araddr), .S_AXI_ARLEN(s_arlen),
        .S_AXI_RVALID(s_rvalid), .S_AXI_RREADY(s_rready),
        .S_AXI_RID(s_rid), .S_AXI_RDATA(s_rdata), .S_AXI_RRESP(s_rresp), .S_AXI_RLAST(s_rlast),
        .M_AXI_ARVALID(m_arvalid), .M_AXI_ARREADY(m_arready),
        .M_AXI_ARID(m_arid), .M_AXI_ARADDR(m_araddr), .M_AXI_ARLEN(m_arlen),
        .M_AXI_RVALID(m_rvalid), .M_AXI_RREADY(m_rready),
        .M_AXI_RID(m_rid), .M_AXI_RDATA(m_rdata), .M_AXI_RRESP(m_rresp), .M_AXI_RLAST(m_rlast)
    );

    int checks = 0;
    int errors = 0;

    // Pending upstream requests, one per master.
    bit            req_v   [NM];
    logic [IW-1:0] req_id  [NM];
    logic [AW-1:0] req_addr[NM];
    int            req_len [NM];

    // Traffic knobs.
    int req_pct = 0, max_len = 0, ar_pct = 100, rv_pct = 100, rr_pct = 100;
    bit rr_toggle = 1'b0, stray_en = 1'b0;

    // Transaction model: is a burst owned, has its AR gone downstream, which beat is next.
    bit            busy = 1'b0, dphase = 1'b0;
    int            m_grant = 0, m_last = NM - 1;
    logic [IW-1:0] cur_id;
    logic [AW-1:0] cur_addr;
    int            cur_len = 0, beat = 0;
    int            cycle = 0, beats_done = 0;
    int            obs_log[$];
    int            obs_cyc[$];

    logic [NM-1:0] exp_arready, exp_s_rvalid;
    bit            exp_m_arvalid, exp_m_rready;

    function automatic logic [DW-1:0] pat(logic [AW-1:0] a, int b);
        return (a + 32'(b) * 32'd16) ^ 32'hC0DE_0000;
    endfunction

    function automatic int winner();
        for (int off = 1; off <= NM; off++) begin
            int k;
            k = (m_last + off) % NM;
            if (req_v[k]) return k;
        end
        return -1;
    endfunction

    function automatic bit all_idle();
        bit any;
        any = 1'b0;
        for (int k = 0; k < NM; k++) any |= req_v[k];
        return !busy && !any;
    endfunction

    task automatic drive_ar();
        for (int k = 0; k < NM; k++) begin
            s_arvalid[k]          = req_v[k];
            s_arid[k*IW +: IW]    = req_id[k];
            s_araddr[k*AW +: AW]  = req_addr[k];
            s_arlen[k*8 +: 8]     = 8'(req_len[k]);
        end
    endtask

    task automatic gen_req(int k, logic [IW-1:0] id, logic [AW-1:0] addr, int len);
        req_v[k]    = 1'b1;
        req_id[k]   = id;
        req_addr[k] = addr;
        req_len[k]  = len;
    endtask

    task automatic sample();
        int w;
        @(negedge clk);
        w = winner();
        exp_arready = '0;
        if (rstn && !busy && w >= 0) exp_arready[w] = 1'b1;
        exp_m_arvalid = busy && !dphase;
        exp_s_rvalid  = '0;
        exp_m_rready  = 1'b0;
        if (busy && dphase) begin
            exp_s_rvalid[m_grant] = m_rvalid;
            exp_m_rready          = s_rready[m_grant];
        end
        for (int k = 0; k < NM; k++) begin
            if (s_arready[k] && s_arvalid[k]) begin
                obs_log.push_back(k);
                obs_cyc.push_back(cycle);
            end
        end
    endtask

    task automatic advance();
        int w;
        bit rhs, pend;
        w    = winner();
        rhs  = busy && dphase && m_rvalid && s_rready[m_grant];
        pend = busy && dphase && m_rvalid && !rhs;
        if (!rstn) begin
            busy = 1'b0; dphase = 1'b0; m_last = NM - 1;
        end else if (!busy && w >= 0) begin
            busy = 1'b1; dphase = 1'b0; m_grant = w; m_last = w;
            cur_id = req_id[w]; cur_addr = req_addr[w]; cur_len = req_len[w];
            req_v[w] = 1'b0;
        end else if (busy && !dphase && m_arready) begin
            dphase = 1'b1; beat = 0;
        end else if (rhs) begin
            beats_done++;
            if (beat == cur_len) begin
                busy = 1'b0; dphase = 1'b0;
            end else begin
                beat++;
            end
        end
        @(posedge clk);
        cycle++;
        #1;
        for (int k = 0; k < NM; k++)
            if (!req_v[k] && req_pct > 0 && int'($urandom_range(99)) < req_pct)
                gen_req(k, IW'($urandom), $urandom, int'($urandom_range(max_len)));
        drive_ar();
        m_arready = int'($urandom_range(99)) < ar_pct;
        if (rr_toggle) s_rready = ~s_rready;
        else for (int k = 0; k < NM; k++) s_rready[k] = int'($urandom_range(99)) < rr_pct;
        if (busy && dphase) begin
            m_rvalid = pend ? 1'b1 : (int'($urandom_range(99)) < rv_pct);
            m_rid    = cur_id;
            m_rdata  = pat(cur_addr, beat);
            m_rresp  = 2'(beat);
            m_rlast  = (beat == cur_len);
        end else begin
            m_rvalid = stray_en;
            m_rid    = '1;
            m_rdata  = 32'hDEAD_BEEF;
            m_rresp  = 2'b10;
            m_rlast  = 1'b1;
        end
    endtask

    task automatic checked_cycle(string tag);
        sample();
        checks++;
        if (s_arready !== exp_arready) begin
            errors++;
            $display("FAIL %s arready @%0d: got %b want %b", tag, cycle, s_arready, exp_arready);
        end
        checks++;
        if (m_arvalid !== exp_m_arvalid) begin
            errors++;
            $display("FAIL %s m_arvalid @%0d: got %b want %b", tag, cycle, m_arvalid, exp_m_arvalid);
        end
        if (exp_m_arvalid) begin
            checks++;
            if ({m_arid, m_araddr, m_arlen} !== {cur_id, cur_addr, 8'(cur_len)}) begin
                errors++;
                $display("FAIL %s m_ar_fields @%0d: got %h/%h/%0d want %h/%h/%0d", tag, cycle,
                         m_arid, m_araddr, m_arlen, cur_id, cur_addr, cur_len);
            end
        end
        checks++;
        if (s_rvalid !== exp_s_rvalid) begin
            errors++;
            $display("FAIL %s s_rvalid @%0d: got %b want %b", tag, cycle, s_rvalid, exp_s_rvalid);
        end
        checks++;
        if (m_rready !== exp_m_rready) begin
            errors++;
            $display("FAIL %s m_rready @%0d: got %b want %b", tag, cycle, m_rready, exp_m_rready);
        end
        if (busy && dphase && m_rvalid && s_rready[m_grant]) begin
            checks++;
            if ({s_rid, s_rdata, s_rresp, s_rlast} !==
                {cur_id, pat(cur_addr, beat), 2'(beat), 1'(beat == cur_len)}) begin
                errors++;
                $display("FAIL %s beat%0d @%0d: got %h/%h/%0d/%b want %h/%h/%0d/%b", tag, beat, cycle,
                         s_rid, s_rdata, s_rresp, s_rlast,
                         cur_id, pat(cur_addr, beat), beat[1:0], beat == cur_len);
            end
        end
        advance();
    endtask

    task automatic drain(string tag, int budget);
        for (int n = 0; n < budget && !all_idle(); n++) checked_cycle(tag);
        checks++;
        if (!all_idle()) begin
            errors++;
            $display("FAIL %s timeout: still busy after %0d cycles, want idle", tag, budget);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        req_pct = 0;
        for (int k = 0; k < NM; k++) gen_req(k, IW'(k), 32'h1000 * (k + 1), 0);
        drive_ar();
        repeat (3) begin
            sample();
            checks++;
            if ({s_arready, m_arvalid, s_rvalid, m_rready} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got arready=%b m_arvalid=%b rvalid=%b m_rready=%b want all 0",
                         s_arready, m_arvalid, s_rvalid, m_rready);
            end
            advance();
        end
        rstn = 1'b1;
        sample();
        checks++;
        if (s_arready !== 2'b01) begin
            errors++;
            $display("FAIL reset_first_grant: got %b want 01", s_arready);
        end
        advance();
        drain("reset_drain", 40);
    endtask

    task automatic test_single();
        int b0;
        b0 = beats_done;
        gen_req(1, 2'd2, 32'h100, 3);
        drive_ar();
        sample();
        checks++;
        if (s_arready !== 2'b10) begin
            errors++;
            $display("FAIL single_arready: got %b want 10", s_arready);
        end
        advance();
        sample();
        checks++;
        if ({m_arvalid, m_arid, m_araddr, m_arlen} !== {1'b1, 2'd2, 32'h100, 8'd3}) begin
            errors++;
            $display("FAIL single_m_ar: got %b/%h/%h/%0d want 1/2/00000100/3", m_arvalid, m_arid, m_araddr, m_arlen);
        end
        advance();
        drain("single", 40);
        checks++;
        if (beats_done - b0 !== 4) begin
            errors++;
            $display("FAIL single_beats: got %0d want 4", beats_done - b0);
        end
    endtask

    task automatic test_contention();
        int s;
        s = obs_log.size();
        max_len = 0;
        for (int k = 0; k < NM; k++) gen_req(k, IW'(k + 1), 32'h40 * (k + 1), 0);
        drive_ar();
        req_pct = 100;
        repeat (24) checked_cycle("contention");
        req_pct = 0;
        drain("contention_drain", 40);
        checks++;
        if (obs_log.size() - s < 7) begin
            errors++;
            $display("FAIL contention_count: got %0d grants want >=7", obs_log.size() - s);
        end else begin
            for (int i = s + 1; i < s + 7; i++) begin
                checks++;
                if (obs_log[i] !== (obs_log[i-1] + 1) % NM || obs_cyc[i] - obs_cyc[i-1] !== 3) begin
                    errors++;
                    $display("FAIL contention_seq[%0d]: got master %0d after %0d cycles want master %0d after 3",
                             i - s, obs_log[i], obs_cyc[i] - obs_cyc[i-1], (obs_log[i-1] + 1) % NM);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int b0;
        b0 = beats_done;
        s_rready = '0;
        rr_toggle = 1'b1;
        gen_req(0, 2'd1, 32'h2000, 7);
        drive_ar();
        drain("backpressure", 80);
        rr_toggle = 1'b0;
        checks++;
        if (beats_done - b0 !== 8) begin
            errors++;
            $display("FAIL backpressure_beats: got %0d want 8", beats_done - b0);
        end
    endtask

    task automatic test_stray();
        stray_en = 1'b1;
        repeat (4) checked_cycle("stray_idle");
        sample();
        checks++;
        if (m_rvalid !== 1'b1 || m_rready !== 1'b0 || s_rvalid !== '0) begin
            errors++;
            $display("FAIL stray_idle_route: got m_rvalid=%b m_rready=%b s_rvalid=%b want 1/0/00",
                     m_rvalid, m_rready, s_rvalid);
        end
        advance();
        gen_req(0, 2'd3, 32'h300, 1);
        drive_ar();
        drain("stray_burst", 40);
        stray_en = 1'b0;
    endtask

    task automatic test_midreset();
        int b0, n;
        gen_req(0, 2'd3, 32'h400, 5);
        drive_ar();
        n = 0;
        while (!(busy && dphase && beat == 2) && n < 30) begin
            checked_cycle("midreset_run");
            n++;
        end
        checks++;
        if (!(busy && dphase && beat == 2)) begin
            errors++;
            $display("FAIL midreset_reach: beat 2 not reached in %0d cycles", n);
        end
        rstn = 1'b0;
        stray_en = 1'b1;
        checked_cycle("midreset_edge");
        sample();
        checks++;
        if ({s_arready, m_arvalid, s_rvalid, m_rready} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got arready=%b m_arvalid=%b rvalid=%b m_rready=%b want all 0",
                     s_arready, m_arvalid, s_rvalid, m_rready);
        end
        advance();
        rstn = 1'b1;
        stray_en = 1'b0;
        b0 = beats_done;
        gen_req(1, 2'd1, 32'h500, 2);
        drive_ar();
        drain("midreset_fresh", 40);
        checks++;
        if (beats_done - b0 !== 3) begin
            errors++;
            $display("FAIL midreset_fresh_beats: got %0d want 3", beats_done - b0);
        end
    endtask

    task automatic test_random();
        req_pct = 40; max_len = 4; ar_pct = 60; rv_pct = 70; rr_pct = 70;
        repeat (800) checked_cycle("random");
        req_pct = 0; ar_pct = 100; rv_pct = 100; rr_pct = 100;
        drain("random_drain", 200);
    endtask

    initial begin
        rstn      = 1'b0;
        s_arvalid = '0; s_arid = '0; s_araddr = '0; s_arlen = '0;
        s_rready  = '1;
        m_arready = 1'b1;
        m_rvalid  = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0;
        for (int k = 0; k < NM; k++) begin
            req_v[k] = 1'b0; req_id[k] = '0; req_addr[k] = '0; req_len[k] = 0;
        end
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_stray();
        test_midreset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
